// File: rtl/digi_ota_array.sv
// digi_ota_array: multi-channel synchronised, glitch-filtered comparator decision block.
// Optional DRIVE tie-release timeout: define DIGI_OTA_TIE_RELEASE_EN.
module digi_ota_array #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_THRESH = 4,
    parameter int unsigned TIE_RELEASE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] out_oe,
    output logic [CHANNELS-1:0] flip_stb,
    output logic                any_valid
);
    localparam logic [7:0] FILT_LAST = 8'(FILT_THRESH - 1);

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        PEND  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_n [SYNC_STAGES];
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] oe_d;
    logic [CHANNELS-1:0] stb_d;

    // Input synchronisers; keep running regardless of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_p[i] <= '0;
                sync_n[i] <= '0;
            end
        end else begin
            sync_p[0] <= vip;
            sync_n[0] <= vin;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_p[i] <= sync_p[i-1];
                sync_n[i] <= sync_n[i-1];
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        state_t     state, state_nxt;
        logic [7:0] cnt, cnt_nxt;
        logic       cand, cand_nxt;
        logic       from_drive, from_drive_nxt;
        logic       sp, sn;
        logic       commit;
`ifdef DIGI_OTA_TIE_RELEASE_EN
        localparam logic [7:0] TIE_LAST = 8'(TIE_RELEASE - 1);
        logic [7:0] tcnt, tcnt_nxt;
`endif

        assign sp = sync_p[SYNC_STAGES-1][g];
        assign sn = sync_n[SYNC_STAGES-1][g];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state      <= HIZ;
                cnt        <= '0;
                cand       <= 1'b0;
                from_drive <= 1'b0;
`ifdef DIGI_OTA_TIE_RELEASE_EN
                tcnt       <= '0;
`endif
            end else begin
                state      <= state_nxt;
                cnt        <= cnt_nxt;
                cand       <= cand_nxt;
                from_drive <= from_drive_nxt;
`ifdef DIGI_OTA_TIE_RELEASE_EN
                tcnt       <= tcnt_nxt;
`endif
            end
        end

        // Decision FSM; commit is applied uniformly at the end
        always_comb begin
            state_nxt      = state;
            cnt_nxt        = cnt;
            cand_nxt       = cand;
            from_drive_nxt = from_drive;
            out_d[g]       = out[g];
            oe_d[g]        = out_oe[g];
            stb_d[g]       = 1'b0;
            commit         = 1'b0;
`ifdef DIGI_OTA_TIE_RELEASE_EN
            tcnt_nxt       = '0;
`endif
            if (!en) begin
                state_nxt = HIZ;
                cnt_nxt   = '0;
                oe_d[g]   = 1'b0;
            end else begin
                case (state)
                    HIZ: begin
                        cnt_nxt = '0;
                        if (sp != sn) begin
                            cand_nxt = sp;
                            if (FILT_THRESH == 1) begin
                                commit = 1'b1;
                            end else begin
                                state_nxt      = PEND;
                                cnt_nxt        = 8'd1;
                                from_drive_nxt = 1'b0;
                            end
                        end
                    end
                    PEND: begin
                        if (sp == sn || (from_drive && sp == out[g])) begin
                            state_nxt = from_drive ? DRIVE : HIZ;
                            cnt_nxt   = '0;
                        end else if (sp == cand) begin
                            if (cnt == FILT_LAST) commit = 1'b1;
                            else cnt_nxt = cnt + 8'd1;
                        end else begin
                            cand_nxt = sp;
                            cnt_nxt  = 8'd1;
                        end
                    end
                    DRIVE: begin
                        cnt_nxt = '0;
                        if (sp != sn && sp != out[g]) begin
                            cand_nxt = sp;
                            if (FILT_THRESH == 1) begin
                                commit = 1'b1;
                            end else begin
                                state_nxt      = PEND;
                                cnt_nxt        = 8'd1;
                                from_drive_nxt = 1'b1;
                            end
                        end
`ifdef DIGI_OTA_TIE_RELEASE_EN
                        else if (sp == sn) begin
                            if (tcnt == TIE_LAST) begin
                                state_nxt = HIZ;
                                oe_d[g]   = 1'b0;
                            end else begin
                                tcnt_nxt = tcnt + 8'd1;
                            end
                        end
`endif
                    end
                    default: begin
                        state_nxt = HIZ;
                        cnt_nxt   = '0;
                    end
                endcase
                if (commit) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    out_d[g]  = cand_nxt;
                    oe_d[g]   = 1'b1;
                    stb_d[g]  = 1'b1;
                end
            end
        end
    end

    // Registered outputs; any_valid tracks the out_oe value loaded alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_oe    <= '0;
            flip_stb  <= '0;
            any_valid <= 1'b0;
        end else begin
            out       <= out_d;
            out_oe    <= oe_d;
            flip_stb  <= stb_d;
            any_valid <= |oe_d;
        end
    end
endmodule
